// File: rtl/dmem_controller.sv
// Word-addressed data memory behind a valid/ready request/response handshake. Optional DMEM_ERR_CHECK_EN flags misaligned/out-of-range requests.
// Latency: resp_valid rises LATENCY+1 edges after the accept edge; one transaction in flight.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
module dmem_controller #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic              err;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] wdata;
    logic [BYTES-1:0]  be;
  } req_t;

  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = DATA_W'(i);
    return m;
  endfunction

  mem_t   mem = init_mem();
  state_t state;
  logic [3:0] cnt;
  req_t   in_req, req_q, cur_req;
  logic   enter_resp;

`ifdef DMEM_ERR_CHECK_EN
  localparam logic [31:0] IN_FIELD = 32'(((64'd1 << IDX_W) - 64'd1) << OFF_W);
  logic addr_err;
  assign addr_err = |(req_addr & ~IN_FIELD);
`else
  logic addr_err;
  logic unused_addr;
  assign addr_err    = 1'b0;
  assign unused_addr = ^req_addr;
`endif

  always_comb begin
    in_req       = '0;
    in_req.we    = req_we;
    in_req.err   = addr_err;
    in_req.idx   = req_addr[OFF_W +: IDX_W];
    in_req.wdata = req_wdata;
    in_req.be    = req_be;
  end

  // With LATENCY=0 the response is formed from the live request on the accept edge.
  assign cur_req    = (state == IDLE) ? in_req : req_q;
  assign enter_resp = rst_n && (((state == IDLE) && req_valid && (LATENCY == 0)) ||
                                ((state == WAIT) && (cnt == 4'd0)));

  always_ff @(posedge clk) begin
    if (enter_resp && cur_req.we && !cur_req.err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (cur_req.be[b]) mem[cur_req.idx][b*8 +: 8] <= cur_req.wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q     <= in_req;
            req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          // First RESP cycle only raises valid; data was captured on entry.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        resp_rdata <= (cur_req.we || cur_req.err) ? '0 : mem[cur_req.idx];
        resp_err   <= cur_req.err;
      end
    end
  end

endmodule
